pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the NPC core. It replaces the hand-written per-stage registers (ID/EX, EX/MEM, MEM/WB) with one block.
- Payload is split into two fields:
  - a control field, cleared on bubbles and flushes so that a bubble never carries side effects;
  - a data field, held when the stage is idle.
- Provides a valid/ready handshake, a freeze input for multi-cycle downstream units, and a synchronous flush.
- Optional skid entry (SKID=1) registers in_ready, breaking the combinational ready chain while keeping full throughput.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_slot.sv | 39 +++
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline register.
//   SKID_NONE / SKID_ONE : legal values of the SKID parameter
//   OCC_W                : width of the occupancy count (0..2 entries)
package pipe_pkg;

  localparam int unsigned SKID_NONE = 0;
  localparam int unsigned SKID_ONE  = 1;
  localparam int unsigned OCC_W     = 2;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control field and data field.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   load               : capture ld_ctrl/ld_data and set valid (wins over clear)
//   clear              : drop valid and zero ctrl; data is kept
//   ld_ctrl, ld_data   : payload to capture on load
//   valid, ctrl, data  : registered entry contents
module pipe_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ld_ctrl;
      data  <= ld_data;
    end else if (clear) begin
      // Bubbles never carry side effects, but the data field stays put.
      valid <= 1'b0;
      ctrl  <= '0;
    end
  end

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// freeze (hold), synchronous flush and optional skid entry.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   flush                  : kill all held entries next cycle
//   hold                   : freeze every register, block both handshakes
//   in_valid/in_ready      : upstream handshake; in_ctrl/in_data payload
//   out_valid/out_ready    : downstream handshake; out_ctrl/out_data payload
//   out_fire               : beat retired this cycle (valid & ready & ~hold)
//   occupancy              : registered count of valid entries
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned SKID   = SKID_NONE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_fire,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  logic              in_fire;
  logic              main_valid;
  logic              main_load;
  logic              main_clear;
  logic [CTRL_W-1:0] main_ld_ctrl;
  logic [DATA_W-1:0] main_ld_data;
  logic              main_v_next;
  logic              skid_valid;
  logic              skid_v_next;
  logic [OCC_W-1:0]  occ_q;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready & ~hold;
  assign out_valid = main_valid;
  assign occupancy = occ_q;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load),
    .clear   (main_clear),
    .ld_ctrl (main_ld_ctrl),
    .ld_data (main_ld_data),
    .valid   (main_valid),
    .ctrl    (out_ctrl),
    .data    (out_data)
  );

  generate
    if (SKID == SKID_NONE) begin : g_single
      assign in_ready     = ~rst & ~hold & ~flush & (~main_valid | out_ready);
      assign main_load    = in_fire;
      assign main_clear   = flush | (out_fire & ~in_fire);
      assign main_ld_ctrl = in_ctrl;
      assign main_ld_data = in_data;
      assign skid_valid   = 1'b0;
      assign skid_v_next  = 1'b0;
    end else begin : g_skid
      logic              skid_load;
      logic              skid_clear;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      // Ready depends only on registered skid state plus hold/flush, so the
      // downstream ready never propagates combinationally to upstream.
      assign in_ready = ~rst & ~skid_valid & ~hold & ~flush;

      // Main refills either from the skid entry (when it holds the older
      // beat) or straight from the input. in_fire and a valid skid are
      // mutually exclusive, so skid_valid alone selects the source.
      // out_fire may still be high during flush; flush must win.
      assign main_load    = ~flush &
                            ((in_fire & (~main_valid | out_fire)) |
                             (out_fire & skid_valid));
      assign main_clear   = flush | (out_fire & ~skid_valid & ~in_fire);
      assign main_ld_ctrl = skid_valid ? skid_ctrl : in_ctrl;
      assign main_ld_data = skid_valid ? skid_data : in_data;

      assign skid_load    = in_fire & main_valid & ~out_fire;
      assign skid_clear   = flush | (out_fire & skid_valid);
      assign skid_v_next  = skid_load | (skid_valid & ~skid_clear);

      pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .clear   (skid_clear),
        .ld_ctrl (in_ctrl),
        .ld_data (in_data),
        .valid   (skid_valid),
        .ctrl    (skid_ctrl),
        .data    (skid_data)
      );
    end
  endgenerate

  assign main_v_next = main_load | (main_valid & ~main_clear);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= OCC_W'(main_v_next) + OCC_W'(skid_v_next);
    end
  end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 32;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          hold;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          ir  [2];
  logic          ov  [2];
  logic          of  [2];
  logic [CW-1:0] oc  [2];
  logic [DW-1:0] od  [2];
  logic [1:0]    occ [2];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_fire(of[0]),
    .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0])
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_fire(of[1]),
    .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1])
  );

  // Reference model: each stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
  // The visible data field is whatever beat last reached the head.
  beat_t         q0[$];
  beat_t         q1[$];
  logic [DW-1:0] md[2] = '{'0, '0};

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qfront(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  function automatic bit e_in_ready(int k);
    if (rst || flush || hold) return 1'b0;
    if (k == 0) return (qsize(0) == 0) || out_ready;
    return qsize(1) < 2;
  endfunction

  function automatic bit e_valid(int k);
    return qsize(k) != 0;
  endfunction

  function automatic bit e_fire(int k);
    return e_valid(k) && out_ready && !hold;
  endfunction

  function automatic logic [CW-1:0] e_ctrl(int k);
    beat_t b;
    if (!e_valid(k)) return '0;
    b = qfront(k);
    return b.c;
  endfunction

  function automatic logic [1:0] e_occ(int k);
    return 2'(qsize(k));
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    md[0] = '0;
    md[1] = '0;
  endtask

  // Advance one clock: decide transfers from the inputs as they stand,
  // wait for the edge, then apply them to the model.
  task automatic tick();
    bit    inf [2];
    bit    outf[2];
    bit    fl, hd;
    beat_t nb;
    for (int k = 0; k < 2; k++) begin
      inf[k]  = in_valid && e_in_ready(k);
      outf[k] = e_fire(k);
    end
    fl   = flush;
    hd   = hold;
    nb.c = in_ctrl;
    nb.d = in_data;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        if (k == 0) q0.delete(); else q1.delete();
      end else if (!hd) begin
        if (outf[k]) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (inf[k]) begin
          if (k == 0) q0.push_back(nb); else q1.push_back(nb);
        end
      end
      if (qsize(k) != 0) begin
        beat_t h;
        h = qfront(k);
        md[k] = h.d;
      end
    end
  endtask

  task automatic idle_inputs();
    flush = 0; hold = 0; in_valid = 0; out_ready = 0;
    in_ctrl = '0; in_data = '0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] dv;
    idle_inputs();
    dv = $urandom;
    in_valid = 1; in_ctrl = 8'hA5; in_data = dv;
    #1;
    tick();
    in_valid = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ov[k] !== 1'b1 || oc[k] !== 8'hA5 || od[k] !== dv) begin
        fails++;
        $display("FAIL reset_preload dut%0d: got v=%b c=%h d=%h want v=1 c=a5 d=%h",
                 k, ov[k], oc[k], od[k], dv);
      end
    end
    #2 rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || oc[k] !== '0 || od[k] !== '0 || occ[k] !== 2'd0 || ir[k] !== 1'b0) begin
        fails++;
        $display("FAIL reset_async dut%0d: got v=%b c=%h d=%h occ=%0d rdy=%b want all 0",
                 k, ov[k], oc[k], od[k], occ[k], ir[k]);
      end
    end
    model_reset();
    rst = 0;
    #1;
  endtask

  task automatic test_stream();
    idle_inputs();
    out_ready = 1;
    in_valid  = 1;
    for (int i = 1; i <= 10; i++) begin
      in_data = DW'(i);
      in_ctrl = 8'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ir[k] !== 1'b1) begin
          fails++;
          $display("FAIL stream_ready dut%0d beat %0d: got %b want 1", k, i, ir[k]);
        end
        if (i > 1) begin
          checks++;
          if (of[k] !== 1'b1 || od[k] !== DW'(i - 1) || oc[k] !== e_ctrl(k)) begin
            fails++;
            $display("FAIL stream_out dut%0d beat %0d: got fire=%b d=%0d c=%h want fire=1 d=%0d c=%h",
                     k, i, of[k], od[k], oc[k], i - 1, e_ctrl(k));
          end
        end
      end
      tick();
    end
    in_valid = 0;
    #1;
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] bv[3];
    logic [DW-1:0] got[$];
    int            idx;
    idle_inputs();
    for (int i = 0; i < 3; i++) bv[i] = $urandom;
    idx = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      in_valid = (idx < 3);
      in_data  = bv[(idx < 3) ? idx : 2];
      in_ctrl  = 8'(idx + 1);
      #1;
      if (in_valid && e_in_ready(1)) idx++;
      tick();
    end
    in_valid = 1; in_data = bv[2]; in_ctrl = 8'd3;
    #1;
    checks++;
    if (occ[1] !== 2'd2 || ir[1] !== 1'b0 || od[1] !== bv[0] || ov[1] !== 1'b1) begin
      fails++;
      $display("FAIL bp_full: got occ=%0d rdy=%b d=%h v=%b want occ=2 rdy=0 d=%h v=1",
               occ[1], ir[1], od[1], ov[1], bv[0]);
    end
    out_ready = 1;
    for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
      #1;
      if (of[1] === 1'b1) got.push_back(od[1]);
      if (in_valid && e_in_ready(1)) begin
        tick();
        in_valid = 0;
      end else begin
        tick();
      end
    end
    checks++;
    if (got.size() != 3) begin
      fails++;
      $display("FAIL bp_count: got %0d beats want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== bv[i]) begin
          fails++;
          $display("FAIL bp_order beat %0d: got %h want %h", i, got[i], bv[i]);
        end
      end
    end
    in_valid = 0;
    #1;
    tick();
  endtask

  task automatic test_hold();
    logic [DW-1:0] dd, de;
    idle_inputs();
    dd = $urandom; de = $urandom;
    out_ready = 1; in_valid = 1; in_data = dd; in_ctrl = 8'h11;
    #1;
    tick();
    in_data = de; in_ctrl = 8'h22; hold = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ir[k] !== 1'b0 || of[k] !== 1'b0 || ov[k] !== 1'b1 || od[k] !== dd || oc[k] !== 8'h11) begin
          fails++;
          $display("FAIL hold_stable dut%0d c%0d: got rdy=%b fire=%b v=%b d=%h c=%h want 0 0 1 %h 11",
                   k, c, ir[k], of[k], ov[k], od[k], oc[k], dd);
        end
      end
      tick();
    end
    hold = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (of[k] !== 1'b1 || od[k] !== dd) begin
        fails++;
        $display("FAIL hold_release dut%0d: got fire=%b d=%h want 1 %h", k, of[k], od[k], dd);
      end
    end
    tick();
    in_valid = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ov[k] !== 1'b1 || od[k] !== de || oc[k] !== 8'h22) begin
        fails++;
        $display("FAIL hold_next dut%0d: got v=%b d=%h c=%h want 1 %h 22", k, ov[k], od[k], oc[k], de);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    logic [DW-1:0] keep;
    idle_inputs();
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_data = $urandom; in_ctrl = 8'($urandom_range(1, 255));
      #1;
      tick();
    end
    keep = md[1];
    flush = 1; in_data = $urandom;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ir[k] !== 1'b0) begin
        fails++;
        $display("FAIL flush_ready dut%0d: got %b want 0", k, ir[k]);
      end
    end
    checks++;
    if (occ[1] !== 2'd2) begin
      fails++;
      $display("FAIL flush_pre_occ: got %0d want 2", occ[1]);
    end
    tick();
    flush = 0; in_valid = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (occ[k] !== 2'd0 || ov[k] !== 1'b0 || oc[k] !== '0 || od[k] !== md[k]) begin
        fails++;
        $display("FAIL flush_after dut%0d: got occ=%0d v=%b c=%h d=%h want 0 0 00 %h",
                 k, occ[k], ov[k], oc[k], od[k], md[k]);
      end
    end
    checks++;
    if (od[1] !== keep) begin
      fails++;
      $display("FAIL flush_data_kept: got %h want %h", od[1], keep);
    end
    tick();
  endtask

  task automatic test_bubble();
    logic [DW-1:0] x;
    idle_inputs();
    x = $urandom;
    out_ready = 1; in_valid = 1; in_ctrl = 8'hFF; in_data = x;
    #1;
    tick();
    in_valid = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (of[k] !== 1'b1 || oc[k] !== 8'hFF) begin
        fails++;
        $display("FAIL bubble_fire dut%0d: got fire=%b c=%h want 1 ff", k, of[k], oc[k]);
      end
    end
    tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || oc[k] !== 8'h00 || od[k] !== x) begin
        fails++;
        $display("FAIL bubble_zero dut%0d: got v=%b c=%h d=%h want 0 00 %h", k, ov[k], oc[k], od[k], x);
      end
    end
    tick();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      hold      = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_ctrl   = 8'($urandom);
      in_data   = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (ir[k] !== e_in_ready(k) || ov[k] !== e_valid(k) || of[k] !== e_fire(k) ||
            oc[k] !== e_ctrl(k) || od[k] !== md[k] || occ[k] !== e_occ(k)) begin
          fails++;
          $display("FAIL random dut%0d n=%0d: got rdy=%b v=%b fire=%b c=%h d=%h occ=%0d want %b %b %b %h %h %0d",
                   k, n, ir[k], ov[k], of[k], oc[k], od[k], occ[k],
                   e_in_ready(k), e_valid(k), e_fire(k), e_ctrl(k), md[k], e_occ(k));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_flush();
    test_bubble();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule : tb_pipe_stage_reg
